// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transaction scheduler and its arbiter.
package spi_ctrl_pkg;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned RR_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        GAP,
        HOLD,
        DONE
    } sched_state_t;

    // First set bit of mask strictly after 'last', wrapping modulo n; returns last if mask is empty.
    function automatic logic [RR_IDX_W-1:0] next_rr(input logic [MAX_REQ-1:0]  mask,
                                                      input logic [RR_IDX_W-1:0] last,
                                                      input int unsigned         n);
        logic [RR_IDX_W-1:0] pick;
        logic [RR_IDX_W-1:0] cand;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            cand = RR_IDX_W'((32'(last) + i) % n);
            if (!found && (i <= n) && mask[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_txn_sched_if.sv
// Client-side request bus plus byte-master control/status for the transaction scheduler.
interface spi_txn_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4
);
    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*8-1:0]     req_tx_data;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0]       tx_pop;
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic [IDW-1:0]           rx_id;
    logic [NUM_REQ-1:0]       txn_done;
    logic                     busy;
    logic [NUM_REQ-1:0]       dev_cs_n;
    logic                     eng_en;
    logic [7:0]               eng_tx_data;
    logic                     eng_done;
    logic [7:0]               eng_rx_data;

    // Scheduler side.
    modport slave (
        input  req_valid, req_len, req_tx_data, eng_done, eng_rx_data,
        output req_ack, tx_pop, rx_valid, rx_data, rx_id, txn_done, busy,
               dev_cs_n, eng_en, eng_tx_data
    );

    // Client / byte-master side.
    modport master (
        output req_valid, req_len, req_tx_data, eng_done, eng_rx_data,
        input  req_ack, tx_pop, rx_valid, rx_data, rx_id, txn_done, busy,
               dev_cs_n, eng_en, eng_tx_data
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Stateless round-robin arbiter; the caller owns the last-grant register.
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [NUM_REQ-1:0] gnt_oh_o_c,
    output logic [IDW-1:0]     gnt_idx_o_c,
    output logic               gnt_any_o_c
);

    logic [RR_IDX_W-1:0] pick;

    always_comb begin
        pick        = next_rr(MAX_REQ'(req_i), RR_IDX_W'(last_i), NUM_REQ);
        gnt_any_o_c = |req_i;
        gnt_idx_o_c = IDW'(pick);
        gnt_oh_o_c  = gnt_any_o_c ? (NUM_REQ'(1) << pick) : '0;
    end

endmodule

// File: rtl/spi_txn_sched.sv
// Round-robin multi-client transaction scheduler driving a single SPI byte master,
// holding the winner's chip select low across its whole multi-byte transfer.
module spi_txn_sched
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned LEN_W    = $clog2(MAX_LEN),
    parameter int unsigned CS_GUARD = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_txn_sched_if.slave bus
);

    localparam int unsigned   IDW        = $clog2(NUM_REQ);
    localparam int unsigned   CW         = LEN_W + 1;
    localparam int unsigned   GW         = $clog2(CS_GUARD + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD - 1);

    sched_state_t       state_q, state_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      guard_q, guard_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] pop_q, pop_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               eng_en_q, eng_en_d;
    logic               rx_valid_q, rx_valid_d;
    logic               busy_q, busy_d;
    logic [7:0]         eng_tx_q, eng_tx_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [IDW-1:0]     rx_id_q, rx_id_d;

    logic [LEN_W-1:0]   len_a [NUM_REQ];
    logic [7:0]         txd_a [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] gid_oh;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;

    // Per-requester views of the flattened request fields.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign len_a[i] = bus.req_len[i*LEN_W +: LEN_W];
        assign txd_a[i] = bus.req_tx_data[i*8 +: 8];
    end

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (bus.req_valid),
        .last_i      (last_q),
        .gnt_oh_o_c  (gnt_oh),
        .gnt_idx_o_c (gnt_idx),
        .gnt_any_o_c (gnt_any)
    );

    assign gid_oh = NUM_REQ'(1) << gid_q;

    always_comb begin
        state_d    = state_q;
        gid_d      = gid_q;
        last_d     = last_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        guard_d    = guard_q;
        cs_n_d     = cs_n_q;
        eng_en_d   = eng_en_q;
        eng_tx_d   = eng_tx_q;
        rx_data_d  = rx_data_q;
        rx_id_d    = rx_id_q;
        ack_d      = '0;
        pop_d      = '0;
        done_d     = '0;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    gid_d   = gnt_idx;
                    len_d   = len_a[gnt_idx];
                    cnt_d   = '0;
                    guard_d = '0;
                    ack_d   = gnt_oh;
                    cs_n_d  = ~gnt_oh;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    state_d = LOAD;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            LOAD: begin
                eng_tx_d = txd_a[gid_q];
                pop_d    = gid_oh;
                eng_en_d = 1'b1;
                state_d  = XFER;
            end
            XFER: begin
                if (bus.eng_done) begin
                    rx_data_d  = bus.eng_rx_data;
                    rx_id_d    = gid_q;
                    rx_valid_d = 1'b1;
                    eng_en_d   = 1'b0;
                    if (cnt_q == {1'b0, len_q}) begin
                        guard_d = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = GAP;
                    end
                end
            end
            // Extra idle cycle so the byte master sees eng_en low long enough to rearm.
            GAP: begin
                state_d = LOAD;
            end
            HOLD: begin
                if (guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    state_d = DONE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            DONE: begin
                cs_n_d  = '1;
                done_d  = gid_oh;
                last_d  = gid_q;
                state_d = IDLE;
            end
            default: begin
                cs_n_d   = '1;
                eng_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gid_q      <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            len_q      <= '0;
            cnt_q      <= '0;
            guard_q    <= '0;
            cs_n_q     <= '1;
            ack_q      <= '0;
            pop_q      <= '0;
            done_q     <= '0;
            eng_en_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            eng_tx_q   <= '0;
            rx_data_q  <= '0;
            rx_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            gid_q      <= gid_d;
            last_q     <= last_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            cs_n_q     <= cs_n_d;
            ack_q      <= ack_d;
            pop_q      <= pop_d;
            done_q     <= done_d;
            eng_en_q   <= eng_en_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            eng_tx_q   <= eng_tx_d;
            rx_data_q  <= rx_data_d;
            rx_id_q    <= rx_id_d;
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.tx_pop      = pop_q;
    assign bus.txn_done    = done_q;
    assign bus.dev_cs_n    = cs_n_q;
    assign bus.eng_en      = eng_en_q;
    assign bus.eng_tx_data = eng_tx_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_id       = rx_id_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_txn_sched.sv
// Directed bench for spi_txn_sched: client models, a fixed-latency byte-master model
// and hand-computed expectations checked with immediate assertions.
module tb_spi_txn_sched;

    localparam int NREQ     = 4;
    localparam int MAXLEN   = 16;
    localparam int LENW     = 4;
    localparam int GUARD    = 2;
    localparam int ENG_LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_txn_sched_if #(.NUM_REQ(NREQ), .LEN_W(LENW)) bus ();

    spi_txn_sched #(
        .NUM_REQ  (NREQ),
        .MAX_LEN  (MAXLEN),
        .LEN_W    (LENW),
        .CS_GUARD (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0] rv = '0;
    logic [LENW-1:0] len_v [NREQ];
    logic [7:0]      tx_b  [NREQ];
    int              reps  [NREQ];
    logic            eng_done_m = 1'b0;
    logic            spur       = 1'b0;
    logic [7:0]      eng_rx_m   = '0;
    int              eng_cnt    = 0;

    assign bus.req_valid   = rv;
    assign bus.req_len     = {len_v[3], len_v[2], len_v[1], len_v[0]};
    assign bus.req_tx_data = {tx_b[3], tx_b[2], tx_b[1], tx_b[0]};
    assign bus.eng_done    = eng_done_m | spur;
    assign bus.eng_rx_data = eng_rx_m;

    int         n_pass  = 0;
    int         n_total = 0;
    int         pop_cnt  [NREQ];
    int         done_cnt [NREQ];
    int         cs_run   [NREQ];
    int         cs_len   [NREQ];
    int         cs_rises [NREQ];
    int         overlap_err = 0;
    int         min_gap     = 99;
    int         low_run     = 0;
    bit         had_high    = 1'b0;
    logic [7:0] rx_q [$];
    int         rxid_q [$];
    int         gnt_q [$];

    // Byte master: done pulse on the ENG_LAT-th cycle of eng_en high, reply = tx ^ 0x99.
    always @(negedge clk) begin
        if (eng_done_m) begin
            eng_done_m = 1'b0;
            eng_cnt    = 0;
        end else if (bus.eng_en) begin
            eng_cnt++;
            if (eng_cnt == ENG_LAT) begin
                eng_done_m = 1'b1;
                eng_rx_m   = bus.eng_tx_data ^ 8'h99;
            end
        end else begin
            eng_cnt = 0;
        end
    end

    // Clients and observers.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (bus.tx_pop[i]) begin
                pop_cnt[i]++;
                tx_b[i] = tx_b[i] + 8'd1;
            end
            if (bus.txn_done[i]) done_cnt[i]++;
            if (bus.req_ack[i]) begin
                gnt_q.push_back(i);
                if (reps[i] > 0) reps[i]--;
                else rv[i] = 1'b0;
            end
            if (!bus.dev_cs_n[i]) begin
                cs_run[i]++;
            end else if (cs_run[i] > 0) begin
                cs_len[i] = cs_run[i];
                cs_rises[i]++;
                cs_run[i] = 0;
            end
        end
        if ($countones(~bus.dev_cs_n) > 1) overlap_err++;
        if (bus.rx_valid) begin
            rx_q.push_back(bus.rx_data);
            rxid_q.push_back(int'(bus.rx_id));
        end
        if (bus.eng_en) begin
            if (had_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
            had_high = 1'b1;
            low_run  = 0;
        end else if (had_high) begin
            low_run++;
        end
        if ((|bus.txn_done) || rst) begin
            had_high = 1'b0;
            low_run  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_txn(input int idx, input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt[idx] < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt[idx] >= target), 32'd1);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rxid_q.delete();
        gnt_q.delete();
        for (int i = 0; i < NREQ; i++) cs_rises[i] = 0;
        min_gap = 99;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            len_v[i] = '0;
            tx_b[i]  = '0;
            reps[i]  = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_cs_n",     32'(bus.dev_cs_n),    32'hF);
        chk("rst_eng_en",   32'(bus.eng_en),      32'h0);
        chk("rst_busy",     32'(bus.busy),        32'h0);
        chk("rst_ack",      32'(bus.req_ack),     32'h0);
        chk("rst_pop",      32'(bus.tx_pop),      32'h0);
        chk("rst_rx_valid", 32'(bus.rx_valid),    32'h0);
        chk("rst_done",     32'(bus.txn_done),    32'h0);
        chk("rst_eng_tx",   32'(bus.eng_tx_data), 32'h0);
        chk("rst_rx_data",  32'(bus.rx_data),     32'h0);
        chk("rst_rx_id",    32'(bus.rx_id),       32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single 1-byte transaction on requester 0, cycle-exact start.
        clear_obs();
        tx_b[0]  = 8'hA5;
        len_v[0] = 4'd0;
        rv[0]    = 1'b1;
        @(negedge clk);
        chk("t1_ack",  32'(bus.req_ack),  32'h1);
        chk("t1_cs_n", 32'(bus.dev_cs_n), 32'hE);
        chk("t1_busy", 32'(bus.busy),     32'h1);
        repeat (2) @(negedge clk);
        chk("t1_en_early", 32'(bus.eng_en), 32'h0);
        @(negedge clk);
        chk("t1_en_first", 32'(bus.eng_en),      32'h1);
        chk("t1_pop",      32'(bus.tx_pop),      32'h1);
        chk("t1_eng_tx",   32'(bus.eng_tx_data), 32'hA5);
        wait_txn(0, 1, "t1_done_wait");
        chk("t1_pops",   32'(pop_cnt[0]),   32'd1);
        chk("t1_rx_n",   32'(rx_q.size()),  32'd1);
        chk("t1_rx",     32'(rx_q[0]),      32'h3C);
        chk("t1_rx_id",  32'(rxid_q[0]),    32'd0);
        chk("t1_cs_len", 32'(cs_len[0]),    32'd9);
        chk("t1_cs_one", 32'(cs_rises[0]),  32'd1);

        // 4-byte transaction on requester 2.
        @(negedge clk);
        clear_obs();
        tx_b[2]  = 8'h01;
        len_v[2] = 4'd3;
        rv[2]    = 1'b1;
        wait_txn(2, 1, "t2_done_wait");
        chk("t2_pops",    32'(pop_cnt[2]),   32'd4);
        chk("t2_rx_n",    32'(rx_q.size()),  32'd4);
        chk("t2_rx0",     32'(rx_q[0]),      32'h98);
        chk("t2_rx1",     32'(rx_q[1]),      32'h9B);
        chk("t2_rx2",     32'(rx_q[2]),      32'h9A);
        chk("t2_rx3",     32'(rx_q[3]),      32'h9D);
        chk("t2_rx_id",   32'(rxid_q[3]),    32'd2);
        chk("t2_gap_ge2", 32'(min_gap >= 2), 32'd1);
        chk("t2_cs_one",  32'(cs_rises[2]),  32'd1);
        chk("t2_cs_len",  32'(cs_len[2]),    32'd24);

        // Maximum length on requester 3: exactly MAXLEN bytes, one txn_done.
        @(negedge clk);
        clear_obs();
        tx_b[3]  = 8'h40;
        len_v[3] = 4'd15;
        rv[3]    = 1'b1;
        wait_txn(3, 1, "t4_done_wait");
        repeat (20) @(negedge clk);
        chk("t4_pops",   32'(pop_cnt[3]),  32'd16);
        chk("t4_rx_n",   32'(rx_q.size()), 32'd16);
        chk("t4_rx0",    32'(rx_q[0]),     32'hD9);
        chk("t4_rx15",   32'(rx_q[15]),    32'hD6);
        chk("t4_rx_id",  32'(rxid_q[15]),  32'd3);
        chk("t4_done_n", 32'(done_cnt[3]), 32'd1);
        chk("t4_idle",   32'(bus.busy),    32'h0);

        // Requesters 0, 1, 3 competing (0 asks twice): round-robin order 0,1,3,0.
        clear_obs();
        len_v[0] = 4'd0;
        len_v[1] = 4'd0;
        len_v[3] = 4'd0;
        reps[0]  = 1;
        overlap_err = 0;
        rv = 4'b1011;
        wait_txn(0, 3, "t3_done_wait");
        chk("t3_gnt_n", 32'(gnt_q.size()), 32'd4);
        chk("t3_gnt0",  32'(gnt_q[0]),     32'd0);
        chk("t3_gnt1",  32'(gnt_q[1]),     32'd1);
        chk("t3_gnt2",  32'(gnt_q[2]),     32'd3);
        chk("t3_gnt3",  32'(gnt_q[3]),     32'd0);
        chk("t3_cs_overlap", 32'(overlap_err), 32'd0);

        // Reset during the second byte of a requester-1 transfer.
        @(negedge clk);
        clear_obs();
        tx_b[1]  = 8'h10;
        len_v[1] = 4'd3;
        rv[1]    = 1'b1;
        n = 0;
        while (pop_cnt[1] < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_byte2", 32'(pop_cnt[1]), 32'd3);
        chk("t5_in_xfer",     32'(bus.eng_en), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cs_n",  32'(bus.dev_cs_n), 32'hF);
        chk("t5_en",    32'(bus.eng_en),   32'h0);
        chk("t5_busy",  32'(bus.busy),     32'h0);
        rst = 1'b0;
        @(negedge clk);
        clear_obs();
        len_v[0] = 4'd0;
        len_v[1] = 4'd0;
        rv = 4'b0011;
        @(negedge clk);
        chk("t5_ack_after_rst", 32'(bus.req_ack), 32'h1);
        wait_txn(0, 4, "t5_done0_wait");
        wait_txn(1, 2, "t5_done1_wait");
        chk("t5_gnt_n", 32'(gnt_q.size()), 32'd2);
        chk("t5_gnt1",  32'(gnt_q[1]),     32'd1);

        // Spurious eng_done in IDLE and in GAP.
        @(negedge clk);
        clear_obs();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("t6_idle_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("t6_idle_busy",     32'(bus.busy),     32'h0);
        tx_b[2]  = 8'h20;
        len_v[2] = 4'd1;
        rv[2]    = 1'b1;
        n = 0;
        while (!bus.rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_rx", 32'(bus.rx_valid), 32'h1);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("t6_gap_rx_valid", 32'(bus.rx_valid), 32'h0);
        wait_txn(2, 2, "t6_done_wait");
        chk("t6_rx_n",  32'(rx_q.size()), 32'd2);
        chk("t6_rx0",   32'(rx_q[0]),     32'hB9);
        chk("t6_rx1",   32'(rx_q[1]),     32'hB8);
        chk("t6_pops",  32'(pop_cnt[2]),  32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
